// File: rtl/mux_scan.sv
// Registered N-to-1 channel mux with an autonomous scan sequencer (IDLE/SCAN).
// Manual mode selects by sel; scan mode walks every channel, dwelling DWELL cycles on each.
module mux_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 16,
  parameter int DWELL    = 1,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      start,
  input  logic                      loop,
  output logic [WIDTH-1:0]          out,
  output logic [SELW-1:0]           ch_out,
  output logic                      valid,
  output logic                      done
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [SELW-1:0]  ch;
  logic [DW-1:0]    dwell;
  logic [WIDTH-1:0] man_data;
  logic [WIDTH-1:0] scan_data;
  logic             man_ok;

  // Decode by equality so out-of-range selects give zero, whatever CHANNELS is.
  always_comb begin
    man_data  = '0;
    scan_data = '0;
    man_ok    = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SELW'(k)) begin
        man_data = in[k*WIDTH +: WIDTH];
        man_ok   = 1'b1;
      end
      if (ch == SELW'(k)) scan_data = in[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ch     <= '0;
      dwell  <= '0;
      out    <= '0;
      ch_out <= '0;
      valid  <= 1'b0;
      done   <= 1'b0;
    end else if (!mode) begin
      state  <= IDLE;
      ch     <= '0;
      dwell  <= '0;
      done   <= 1'b0;
      ch_out <= sel;
      out    <= man_ok ? man_data : '0;
      valid  <= man_ok;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            state <= SCAN;
            ch    <= '0;
            dwell <= '0;
          end
        end
        SCAN: begin
          if (dwell == DW'(DWELL - 1)) begin
            out    <= scan_data;
            ch_out <= ch;
            valid  <= 1'b1;
            dwell  <= '0;
            if (ch == SELW'(CHANNELS - 1)) begin
              done <= 1'b1;
              ch   <= '0;
              if (!loop) state <= IDLE;
            end else begin
              done <= 1'b0;
              ch   <= ch + SELW'(1);
            end
          end else begin
            dwell <= dwell + DW'(1);
            valid <= 1'b0;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: manual select, single/looped scan, abort and async reset.
module tb_mux_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // one-hot, WIDTH=1 CHANNELS=16
  logic [15:0] oh_in;
  logic [3:0]  oh_sel, oh_ch;
  logic        oh_mode, oh_start, oh_loop, oh_out, oh_valid, oh_done;
  // wide, WIDTH=8 CHANNELS=5
  logic [39:0] wd_in;
  logic [2:0]  wd_sel, wd_ch;
  logic [7:0]  wd_out;
  logic        wd_mode, wd_start, wd_loop, wd_valid, wd_done;
  // scan, WIDTH=8 CHANNELS=4, DWELL=3 / 1 / 2
  logic [31:0] s3_in, s1_in, s2_in;
  logic [1:0]  s3_sel, s1_sel, s2_sel, s3_ch, s1_ch, s2_ch;
  logic [7:0]  s3_out, s1_out, s2_out;
  logic        s3_mode, s3_start, s3_loop, s3_valid, s3_done;
  logic        s1_mode, s1_start, s1_loop, s1_valid, s1_done;
  logic        s2_mode, s2_start, s2_loop, s2_valid, s2_done;

  mux_scan #(.WIDTH(1), .CHANNELS(16), .DWELL(1)) u_oh (
    .clk(clk), .rst_n(rst_n), .in(oh_in), .sel(oh_sel), .mode(oh_mode), .start(oh_start),
    .loop(oh_loop), .out(oh_out), .ch_out(oh_ch), .valid(oh_valid), .done(oh_done));

  mux_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) u_wd (
    .clk(clk), .rst_n(rst_n), .in(wd_in), .sel(wd_sel), .mode(wd_mode), .start(wd_start),
    .loop(wd_loop), .out(wd_out), .ch_out(wd_ch), .valid(wd_valid), .done(wd_done));

  mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in(s3_in), .sel(s3_sel), .mode(s3_mode), .start(s3_start),
    .loop(s3_loop), .out(s3_out), .ch_out(s3_ch), .valid(s3_valid), .done(s3_done));

  mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in(s1_in), .sel(s1_sel), .mode(s1_mode), .start(s1_start),
    .loop(s1_loop), .out(s1_out), .ch_out(s1_ch), .valid(s1_valid), .done(s1_done));

  mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in(s2_in), .sel(s2_sel), .mode(s2_mode), .start(s2_start),
    .loop(s2_loop), .out(s2_out), .ch_out(s2_ch), .valid(s2_valid), .done(s2_done));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    oh_in = '0; oh_sel = '0; oh_mode = 1'b0; oh_start = 1'b1; oh_loop = 1'b1;
    wd_in = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0}; wd_sel = '0; wd_mode = 1'b0;
    wd_start = 1'b0; wd_loop = 1'b0;
    s3_in = {8'd4, 8'd3, 8'd2, 8'd1}; s3_sel = '0; s3_mode = 1'b1; s3_start = 1'b0; s3_loop = 1'b0;
    s1_in = {8'h13, 8'h12, 8'h11, 8'h10}; s1_sel = '0; s1_mode = 1'b1; s1_start = 1'b0; s1_loop = 1'b1;
    s2_in = {8'h23, 8'h22, 8'h21, 8'h20}; s2_sel = 2'd2; s2_mode = 1'b1; s2_start = 1'b0; s2_loop = 1'b0;

    tick(); tick();
    check("rst_oh", {oh_done, oh_valid, oh_ch, 7'd0, oh_out}, 32'd0);
    check("rst_wd", {wd_done, wd_valid, wd_ch, wd_out}, 32'd0);
    check("rst_s3", {s3_done, s3_valid, s3_ch, s3_out}, 32'd0);
    check("rst_s1", {s1_done, s1_valid, s1_ch, s1_out}, 32'd0);
    check("rst_s2", {s2_done, s2_valid, s2_ch, s2_out}, 32'd0);
    rst_n = 1'b1;

    // Manual one-hot; start held high to confirm it is ignored in manual mode.
    for (int k = 0; k < 16; k++) begin
      oh_in  = 16'(1) << k;
      oh_sel = 4'(k);
      for (int c = 0; c < 5; c++) begin
        tick();
        check($sformatf("oh_out k%0d c%0d", k, c), 32'(oh_out), 32'd1);
        check($sformatf("oh_ch k%0d c%0d", k, c), 32'(oh_ch), k);
        check($sformatf("oh_valid k%0d c%0d", k, c), 32'(oh_valid), 32'd1);
      end
      check($sformatf("oh_done k%0d", k), 32'(oh_done), 32'd0);
      oh_sel = 4'((k + 1) % 16);
      tick();
      check($sformatf("oh_other k%0d", k), 32'(oh_out), 32'd0);
    end

    // Manual wide with out-of-range selects.
    wd_sel = 3'd3; tick();
    check("wd_out3", 32'(wd_out), 32'hA3); check("wd_ch3", 32'(wd_ch), 32'd3);
    check("wd_valid3", 32'(wd_valid), 32'd1);
    wd_sel = 3'd6; tick();
    check("wd_out6", 32'(wd_out), 32'd0); check("wd_ch6", 32'(wd_ch), 32'd6);
    check("wd_valid6", 32'(wd_valid), 32'd0);
    wd_sel = 3'd4; tick();
    check("wd_out4", 32'(wd_out), 32'hA4); check("wd_valid4", 32'(wd_valid), 32'd1);
    wd_sel = 3'd5; tick();
    check("wd_out5", 32'(wd_out), 32'd0); check("wd_valid5", 32'(wd_valid), 32'd0);
    wd_sel = 3'd0; tick();
    check("wd_out0", 32'(wd_out), 32'hA0); check("wd_valid0", 32'(wd_valid), 32'd1);

    // Single scan, DWELL=3; a start at edge 4 must not restart the pass.
    s3_start = 1'b1; tick(); s3_start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) s3_start = 1'b1;
      tick();
      s3_start = 1'b0;
      check($sformatf("s3_valid e%0d", e), 32'(s3_valid), 32'(e % 3 == 0));
      check($sformatf("s3_out e%0d", e), 32'(s3_out), e / 3);
      check($sformatf("s3_ch e%0d", e), 32'(s3_ch), (e < 3) ? 0 : (e / 3 - 1));
      check($sformatf("s3_done e%0d", e), 32'(s3_done), 32'(e == 12));
    end
    s3_start = 1'b1; tick(); s3_start = 1'b0;
    check("s3_idle13_valid", 32'(s3_valid), 32'd0); check("s3_idle13_done", 32'(s3_done), 32'd0);
    tick(); check("s3_re14_valid", 32'(s3_valid), 32'd0);
    tick(); check("s3_re15_valid", 32'(s3_valid), 32'd0);
    tick();
    check("s3_re16_valid", 32'(s3_valid), 32'd1); check("s3_re16_out", 32'(s3_out), 32'd1);
    check("s3_re16_ch", 32'(s3_ch), 32'd0);

    // Looped scan, DWELL=1; drop loop mid-pass.
    s1_start = 1'b1; tick(); s1_start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 11) s1_loop = 1'b0;
      tick();
      check($sformatf("s1_valid e%0d", e), 32'(s1_valid), 32'd1);
      check($sformatf("s1_ch e%0d", e), 32'(s1_ch), (e - 1) % 4);
      check($sformatf("s1_out e%0d", e), 32'(s1_out), 32'h10 + (e - 1) % 4);
      check($sformatf("s1_done e%0d", e), 32'(s1_done), 32'((e - 1) % 4 == 3));
    end
    for (int e = 13; e <= 14; e++) begin
      tick();
      check($sformatf("s1_idle_valid e%0d", e), 32'(s1_valid), 32'd0);
      check($sformatf("s1_idle_done e%0d", e), 32'(s1_done), 32'd0);
      check($sformatf("s1_idle_out e%0d", e), 32'(s1_out), 32'h13);
      check($sformatf("s1_idle_ch e%0d", e), 32'(s1_ch), 32'd3);
    end

    // Abort at edge 5 of a DWELL=2 scan.
    s2_start = 1'b1; tick(); s2_start = 1'b0;
    tick(); check("s2_e1_valid", 32'(s2_valid), 32'd0);
    tick(); check("s2_e2_valid", 32'(s2_valid), 32'd1); check("s2_e2_out", 32'(s2_out), 32'h20);
    tick(); check("s2_e3_valid", 32'(s2_valid), 32'd0);
    tick(); check("s2_e4_valid", 32'(s2_valid), 32'd1); check("s2_e4_out", 32'(s2_out), 32'h21);
    s2_mode = 1'b0;
    for (int e = 5; e <= 8; e++) begin
      tick();
      check($sformatf("s2_man_out e%0d", e), 32'(s2_out), 32'h22);
      check($sformatf("s2_man_ch e%0d", e), 32'(s2_ch), 32'd2);
      check($sformatf("s2_man_valid e%0d", e), 32'(s2_valid), 32'd1);
      check($sformatf("s2_man_done e%0d", e), 32'(s2_done), 32'd0);
    end
    s2_mode = 1'b1; s2_start = 1'b1; tick(); s2_start = 1'b0;
    check("s2_rs_valid", 32'(s2_valid), 32'd0); check("s2_rs_out", 32'(s2_out), 32'h22);
    tick(); check("s2_rs1_valid", 32'(s2_valid), 32'd0);
    tick();
    check("s2_rs2_valid", 32'(s2_valid), 32'd1); check("s2_rs2_out", 32'(s2_out), 32'h20);
    #2 rst_n = 1'b0;
    #1 check("s2_async_rst", {s2_done, s2_valid, s2_ch, s2_out}, 32'd0);
    tick(); check("s2_rst_held", {s2_done, s2_valid, s2_ch, s2_out}, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("s2_quiet c%0d", c), {s2_done, s2_valid, s2_ch, s2_out}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
